// File: rtl/mem_access_unit_if.sv
// Request/response handshake and word-addressed RAM bus for the MEM-stage access unit.
// slave is the unit's view; master is the pipeline plus RAM side.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_rd, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_rd, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: word-aligned RAM cycles, read-modify-write for sub-word
// stores, extended load data, and error reporting for misaligned or out-of-range accesses.
module mem_access_unit #(
    parameter int unsigned RAM_SIZE = 256
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_unit_if.slave   bus
);

    typedef enum logic [2:0] {StIdle, StLd, StSt, StRmwRd, StRmwWr, StErr} state_e;

    state_e      state;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;
    logic        mem_rd_q;
    logic        mem_wr_q;
    logic [31:0] mem_wdata_q;

    logic        req_err;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] merged;

    assign bus.req_ready = (state == StIdle);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata = mem_wdata_q;

    always_comb begin
        req_err = 1'b0;
        unique case (bus.req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = bus.req_addr[0];
            2'b10:   req_err = |bus.req_addr[1:0];
            default: req_err = 1'b1;
        endcase
        if (bus.req_addr >= RAM_SIZE) req_err = 1'b1;
    end

    // Lane extraction and extension of the word returned for a load.
    always_comb begin
        ld_byte = 8'h00;
        unique case (addr_q[1:0])
            2'd0: ld_byte = bus.mem_rdata[7:0];
            2'd1: ld_byte = bus.mem_rdata[15:8];
            2'd2: ld_byte = bus.mem_rdata[23:16];
            2'd3: ld_byte = bus.mem_rdata[31:24];
            default: ld_byte = 8'h00;
        endcase
        ld_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        unique case (size_q)
            2'b00:   ld_data = {{24{signed_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{signed_q & ld_half[15]}}, ld_half};
            default: ld_data = bus.mem_rdata;
        endcase
    end

    // Sub-word store: store data still sits right-justified in mem_wdata_q during RMW_RD.
    always_comb begin
        merged = bus.mem_rdata;
        if (size_q == 2'b00) begin
            unique case (addr_q[1:0])
                2'd0: merged[7:0]   = mem_wdata_q[7:0];
                2'd1: merged[15:8]  = mem_wdata_q[7:0];
                2'd2: merged[23:16] = mem_wdata_q[7:0];
                2'd3: merged[31:24] = mem_wdata_q[7:0];
                default: merged = bus.mem_rdata;
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = mem_wdata_q[15:0];
        end else begin
            merged[15:0] = mem_wdata_q[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= StIdle;
            addr_q      <= 32'h0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= 32'h0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.req_valid) begin
                        addr_q   <= bus.req_addr;
                        size_q   <= bus.req_size;
                        signed_q <= bus.req_signed;
                        if (req_err) begin
                            state <= StErr;
                        end else if (!bus.req_we) begin
                            state    <= StLd;
                            mem_rd_q <= 1'b1;
                        end else begin
                            mem_wdata_q <= bus.req_wdata;
                            if (bus.req_size == 2'b10) begin
                                state    <= StSt;
                                mem_wr_q <= 1'b1;
                            end else begin
                                state    <= StRmwRd;
                                mem_rd_q <= 1'b1;
                            end
                        end
                    end
                end
                StLd: begin
                    mem_rd_q    <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= ld_data;
                    state       <= StIdle;
                end
                StSt, StRmwWr: begin
                    mem_wr_q    <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                    state       <= StIdle;
                end
                StRmwRd: begin
                    mem_rd_q    <= 1'b0;
                    mem_wr_q    <= 1'b1;
                    mem_wdata_q <= merged;
                    state       <= StRmwWr;
                end
                StErr: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    rsp_rdata_q <= 32'h0;
                    state       <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a driver queues expected responses, a monitor checks them
// against the DUT's responses, with a small word RAM attached to the memory bus.
module tb_mem_access_unit;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    int   memops;
    int   mutex_viol;
    int   last_acc;
    logic [31:0] ram [64];
    exp_t exp_q [$];

    mem_access_unit_if bus ();

    mem_access_unit #(.RAM_SIZE(256)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign bus.mem_rdata = ram[bus.mem_addr[7:2]];

    always @(negedge clk) begin
        if (bus.mem_wr) ram[bus.mem_addr[7:2]] = bus.mem_wdata;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: pops one expectation per response pulse.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.mem_rd && bus.mem_wr) mutex_viol++;
            if (bus.mem_rd || bus.mem_wr) memops++;
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d expected none", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e.err});
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk("rsp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic eerr, input logic [31:0] erdata, input int lat,
                         input bit push);
        int n;
        n = 0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout", 32'h0, 32'h1);
            bus.req_valid = 1'b0;
        end else begin
            last_acc = cyc + 1;
            if (push) exp_q.push_back('{eerr, erdata, last_acc + lat});
            @(posedge clk);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = 32'h5A5A_5A5A;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("rsp_timeout", exp_q.size(), 32'h0);
            exp_q.delete();
        end
    endtask

    initial begin
        int m0;
        int acc[6];
        logic [31:0] r1;
        cyc = 0; checks = 0; errors = 0; memops = 0; mutex_viol = 0; last_acc = 0;
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        ram[8]  = 32'h600D_F00D;
        ram[12] = 32'hDEAD_BEEF;
        ram[13] = 32'hCAFE_F00D;
        reset = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'h0, bus.req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("rst_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_mem_rd", {31'h0, bus.mem_rd}, 32'h0);
        chk("rst_mem_wr", {31'h0, bus.mem_wr}, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344, 1'b0, 32'h0, 1, 1'b1);
        drain();
        chk("ram_sw", ram[4], 32'h1122_3344);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h1122_3344, 1, 1'b1);
        drain();
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FFAA, 1'b0, 32'h0, 2, 1'b1);
        drain();
        chk("ram_sb", ram[4], 32'h1122_AA44);
        issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, 32'hFFFF_FFAA, 1, 1'b1);
        issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, 32'h0000_00AA, 1, 1'b1);
        drain();
        issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234_BEEF, 1'b0, 32'h0, 2, 1'b1);
        drain();
        chk("ram_sh", ram[4], 32'hBEEF_AA44);
        issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0, 32'hFFFF_BEEF, 1, 1'b1);
        issue(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0000_AA44, 1, 1'b1);
        drain();

        m0 = memops;
        issue(1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 1'b1, 32'h0, 1, 1'b1);
        drain();
        chk("err_lh_no_mem", memops, m0);
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 1, 1'b1);
        drain();
        r1 = ram[1];
        m0 = memops;
        issue(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEAD_DEAD, 1'b1, 32'h0, 1, 1'b1);
        drain();
        chk("err_sw_no_mem", memops, m0);
        chk("err_sw_ram", ram[1], r1);
        issue(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1'b1, 32'h0, 1, 1'b1);
        issue(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 1'b1, 32'h0, 1, 1'b1);
        drain();

        // req_valid stays high across this whole stream
        issue(1'b1, 2'b00, 1'b0, 32'h31, 32'h0000_0011, 1'b0, 32'h0, 2, 1'b1); acc[0] = last_acc;
        issue(1'b1, 2'b01, 1'b0, 32'h32, 32'h0000_2233, 1'b0, 32'h0, 2, 1'b1); acc[1] = last_acc;
        issue(1'b1, 2'b00, 1'b0, 32'h37, 32'h0000_0044, 1'b0, 32'h0, 2, 1'b1); acc[2] = last_acc;
        issue(1'b1, 2'b01, 1'b0, 32'h34, 32'h0000_5566, 1'b0, 32'h0, 2, 1'b1); acc[3] = last_acc;
        issue(1'b0, 2'b00, 1'b1, 32'h30, 32'h0, 1'b0, 32'hFFFF_FFEF, 1, 1'b1); acc[4] = last_acc;
        issue(1'b0, 2'b01, 1'b0, 32'h36, 32'h0, 1'b0, 32'h0000_44FE, 1, 1'b1); acc[5] = last_acc;
        drain();
        for (int i = 1; i < 4; i++) chk("rmw_spacing", acc[i] - acc[i-1], 32'd3);
        chk("ld_after_rmw_spacing", acc[4] - acc[3], 32'd3);
        chk("ld_spacing", acc[5] - acc[4], 32'd2);
        chk("ram_stream0", ram[12], 32'h2233_11EF);
        chk("ram_stream1", ram[13], 32'h44FE_5566);

        issue(1'b1, 2'b00, 1'b0, 32'h20, 32'h0000_0077, 1'b0, 32'h0, 2, 1'b0);
        #1;
        chk("rmw_rd_active", {31'h0, bus.mem_rd}, 32'h1);
        reset = 1'b0;
        #1;
        chk("midrst_mem_rd", {31'h0, bus.mem_rd}, 32'h0);
        chk("midrst_mem_wr", {31'h0, bus.mem_wr}, 32'h0);
        chk("midrst_ready", {31'h0, bus.req_ready}, 32'h1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_ram", ram[8], 32'h600D_F00D);
        chk("rd_wr_exclusive", mutex_viol, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
